// File: rtl/rd_data_chk_pkg.sv
// Shared constants and state encoding for the frame-buffer read-data checker.
package rd_data_chk_pkg;

    localparam logic ASSERT   = 1'b1;
    localparam logic DEASSERT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MODE_CONST = 0;
    localparam int MODE_ADDR  = 1;

endpackage

// File: rtl/rd_tag_fifo.sv
// Address tag FIFO: holds issuing addresses of outstanding read requests in order.
module rd_tag_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/rd_data_chk.sv
// Read-data checker: matches returned words in order against issuing addresses,
// counts words and errors, and reports registered pass/fail with first-error capture.
module rd_data_chk
    import rd_data_chk_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 32,
    parameter int                CMP_W      = 24,
    parameter int                NUM_WORDS  = 503,
    parameter logic [DATA_W-1:0] TST_PATT   = 24'hFFFFFF,
    parameter int                MODE       = MODE_CONST,
    parameter int                FIFO_DEPTH = 16,
    parameter int                TIMEOUT    = 1024
) (
    input  logic              rd_clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              rd_en_i,
    input  logic              rd_rdy_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_data_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [15:0]       err_cnt_o,
    output logic [ADDR_W-1:0] word_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [DATA_W-1:0] first_err_data_o,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              tmo_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic              busy_q;
    logic              pass_q;
    logic              fail_q;
    logic [15:0]       err_cnt_q;
    logic [15:0]       err_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [ADDR_W-1:0] word_cnt_d;
    logic [ADDR_W-1:0] first_err_addr_q;
    logic [DATA_W-1:0] first_err_data_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              tmo_q;
    logic              tmo_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d;

    logic              run;
    logic              start_ok;
    logic              req;
    logic              vld;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_dout;
    logic [ADDR_W-1:0] exp_addr;
    logic [CMP_W-1:0]  exp_val;
    logic              ovf_evt;
    logic              unf_evt;
    logic              tmo_evt;
    logic              mismatch;
    logic              first_hit;
    logic              done_evt;
    logic              pass_d;

    rd_tag_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i   (rd_clk_i),
        .rst_i   (reset_i),
        .clear_i (start_ok),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (rd_addr_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        run       = (state_q == ST_RUN);
        start_ok  = start_i && !run;
        req       = run && rd_en_i && rd_rdy_i;
        vld       = run && rd_data_valid_i;
        fifo_pop  = vld && !fifo_empty;
        // Data returned into an empty FIFO consumes the same-cycle request directly.
        bypass    = vld && fifo_empty && req;
        fifo_push = req && !bypass && (!fifo_full || fifo_pop);
        ovf_evt   = req && fifo_full && !fifo_pop;
        unf_evt   = vld && fifo_empty && !req;
        exp_addr  = bypass ? rd_addr_i : fifo_dout;
        exp_val   = (MODE == MODE_ADDR) ? exp_addr[CMP_W-1:0] : TST_PATT[CMP_W-1:0];
        mismatch  = vld && (unf_evt || (rd_data_i[CMP_W-1:0] != exp_val));
        first_hit = mismatch && (err_cnt_q == '0);

        tmo_evt   = 1'b0;
        if (rd_data_valid_i || fifo_empty) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            tmo_evt   = run && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
        end

        err_cnt_d  = (mismatch && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
        word_cnt_d = vld ? word_cnt_q + 1'b1 : word_cnt_q;
        ovf_d      = ovf_q | ovf_evt;
        unf_d      = unf_q | unf_evt;
        tmo_d      = tmo_q | tmo_evt;
        done_evt   = run && ((word_cnt_d == ADDR_W'(NUM_WORDS)) || ovf_evt || unf_evt || tmo_evt);
        pass_d     = (err_cnt_d == '0) && !ovf_d && !unf_d && !tmo_d;
    end

    always_ff @(posedge rd_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            busy_q           <= DEASSERT;
            pass_q           <= DEASSERT;
            fail_q           <= DEASSERT;
            err_cnt_q        <= '0;
            word_cnt_q       <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            ovf_q            <= DEASSERT;
            unf_q            <= DEASSERT;
            tmo_q            <= DEASSERT;
            tmo_cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q          <= ST_RUN;
                        busy_q           <= ASSERT;
                        pass_q           <= DEASSERT;
                        fail_q           <= DEASSERT;
                        err_cnt_q        <= '0;
                        word_cnt_q       <= '0;
                        first_err_addr_q <= '0;
                        first_err_data_q <= '0;
                        ovf_q            <= DEASSERT;
                        unf_q            <= DEASSERT;
                        tmo_q            <= DEASSERT;
                        tmo_cnt_q        <= '0;
                    end
                end
                ST_RUN: begin
                    err_cnt_q  <= err_cnt_d;
                    word_cnt_q <= word_cnt_d;
                    tmo_cnt_q  <= tmo_cnt_d;
                    ovf_q      <= ovf_d;
                    unf_q      <= unf_d;
                    tmo_q      <= tmo_d;
                    if (first_hit) begin
                        first_err_addr_q <= unf_evt ? '0 : exp_addr;
                        first_err_data_q <= rd_data_i;
                    end
                    if (done_evt) begin
                        state_q <= ST_DONE;
                        busy_q  <= DEASSERT;
                        pass_q  <= pass_d;
                        fail_q  <= !pass_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;
    assign err_cnt_o        = err_cnt_q;
    assign word_cnt_o       = word_cnt_q;
    assign first_err_addr_o = first_err_addr_q;
    assign first_err_data_o = first_err_data_q;
    assign ovf_o            = ovf_q;
    assign unf_o            = unf_q;
    assign tmo_o            = tmo_q;

endmodule
